// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode encoding, reserved-opcode screen and default datapath width
package alu_pkg;
  localparam int DEFAULT_DATA_W = 32;
  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_RSV2 = 3'b010,
    OP_RSV3 = 3'b011,
    OP_AND  = 3'b100,
    OP_OR   = 3'b101,
    OP_XOR  = 3'b110,
    OP_SLTU = 3'b111
  } opcode_t;
  function automatic logic is_reserved_op(input logic [2:0] op);
    return op[2:1] == 2'b01;
  endfunction
endpackage

// File: rtl/alu.sv
// alu: combinational datapath; reserved codes pass in1 through and are screened upstream
module alu
  import alu_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [2:0]        opcode,
  output logic [DATA_W-1:0] out
);
  always_comb begin
    out = in1;
    case (opcode_t'(opcode))
      OP_ADD:  out = in1 + in2;
      OP_SUB:  out = in1 - in2;
      OP_AND:  out = in1 & in2;
      OP_OR:   out = in1 | in2;
      OP_XOR:  out = in1 ^ in2;
      OP_SLTU: out = DATA_W'(in1 < in2);
      default: out = in1;
    endcase
  end
endmodule

// File: rtl/alu_rsp_fifo.sv
// alu_rsp_fifo: power-of-2 synchronous FIFO; head is read straight from the storage registers
module alu_rsp_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= din;
        wptr      <= wptr + AW'(1);
      end
      if (pop) rptr <= rptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  assign dout  = mem[rptr];
  assign valid = count != '0;
endmodule

// File: rtl/alu_issue.sv
// alu_issue: valid/ready front-end that registers requests, drives the alu and buffers tagged results in order
module alu_issue
  import alu_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int TAG_W      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_in1,
  input  logic [DATA_W-1:0] req_in2,
  input  logic [2:0]        req_opcode,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_err,
  output logic [15:0]       op_cnt,
  output logic [15:0]       err_cnt
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = DATA_W + TAG_W + 1;
  logic              iss_v, iss_err, accept, rsv;
  logic [DATA_W-1:0] iss_in1, iss_in2, alu_out, res;
  logic [2:0]        iss_op;
  logic [TAG_W-1:0]  iss_tag;
  logic [CW-1:0]     count;
  logic [EW-1:0]     head;
  // in-flight issue slot counts against capacity so a push never meets a full FIFO
  assign req_ready = (count + CW'(iss_v)) < CW'(FIFO_DEPTH);
  assign accept    = req_valid && req_ready;
  assign rsv       = is_reserved_op(req_opcode);
  assign res       = iss_err ? '0 : alu_out;
  assign {rsp_data, rsp_tag, rsp_err} = head;
  alu #(.DATA_W(DATA_W)) u_alu (
    .in1   (iss_in1),
    .in2   (iss_in2),
    .opcode(iss_op),
    .out   (alu_out)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_v   <= 1'b0;
      iss_err <= 1'b0;
      iss_in1 <= '0;
      iss_in2 <= '0;
      iss_op  <= '0;
      iss_tag <= '0;
      op_cnt  <= '0;
      err_cnt <= '0;
    end else begin
      iss_v <= accept;
      if (accept) begin
        iss_in1 <= req_in1;
        iss_in2 <= req_in2;
        iss_op  <= req_opcode;
        iss_tag <= req_tag;
        iss_err <= rsv;
      end
      if (accept && !rsv && op_cnt != 16'hFFFF) op_cnt <= op_cnt + 16'd1;
      if (accept && rsv && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end
  alu_rsp_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (iss_v),
    .din  ({res, iss_tag, iss_err}),
    .pop  (rsp_valid && rsp_ready),
    .dout (head),
    .valid(rsp_valid),
    .count(count)
  );
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed and random stimulus against an outstanding-request queue model
module tb_alu_issue;
  localparam int DEPTH = 4;
  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, rsp_valid, rsp_ready = 1'b1, rsp_err;
  logic [31:0] req_in1 = '0, req_in2 = '0, rsp_data;
  logic [2:0]  req_opcode = '0;
  logic [3:0]  req_tag = '0, rsp_tag;
  logic [15:0] op_cnt, err_cnt;
  int          checks = 0, failures = 0, cyc = 0, acc;
  bit          chk_en = 1'b0, m_rdy, mv;
  logic [15:0] m_op = '0, m_err = '0;
  typedef struct {
    logic [31:0] d;
    logic [3:0]  t;
    logic        e;
    int          vis;
  } ent_t;
  ent_t q[$];

  alu_issue dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2), .req_opcode(req_opcode), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .rsp_err(rsp_err), .op_cnt(op_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [31:0] a, b, input logic [2:0] op);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd4: return a & b;
      3'd5: return a | b;
      3'd6: return a ^ b;
      3'd7: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // everything accepted but not yet popped is outstanding; a result is visible one edge after accept
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_op = '0;
      m_err = '0;
      cyc = 0;
    end else begin
      m_rdy = q.size() < DEPTH;
      cyc++;
      if (q.size() > 0 && q[0].vis <= cyc - 1 && rsp_ready) void'(q.pop_front());
      if (req_valid && m_rdy) begin
        q.push_back('{ref_alu(req_in1, req_in2, req_opcode), req_tag,
                      (req_opcode == 3'd2 || req_opcode == 3'd3), cyc + 1});
        if (req_opcode == 3'd2 || req_opcode == 3'd3) begin
          if (m_err != 16'hFFFF) m_err++;
        end else if (m_op != 16'hFFFF) m_op++;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && chk_en) begin
      mv = q.size() > 0 && q[0].vis <= cyc;
      chk("req_ready", 32'(req_ready), 32'(q.size() < DEPTH));
      chk("rsp_valid", 32'(rsp_valid), 32'(mv));
      if (mv && rsp_valid) begin
        chk("rsp_data", rsp_data, q[0].d);
        chk("rsp_tag", 32'(rsp_tag), 32'(q[0].t));
        chk("rsp_err", 32'(rsp_err), 32'(q[0].e));
      end
      chk("op_cnt", 32'(op_cnt), 32'(m_op));
      chk("err_cnt", 32'(err_cnt), 32'(m_err));
    end
  end

  task automatic send(input logic [2:0] op, input logic [31:0] a, b, input logic [3:0] t);
    @(negedge clk);
    req_valid = 1'b1;
    req_opcode = op;
    req_in1 = a;
    req_in2 = b;
    req_tag = t;
  endtask

  task automatic single_op(input string name, input logic [15:0] exp_op);
    rsp_ready = 1'b1;
    send(3'd0, 32'h5, 32'h2, 4'd3);
    @(negedge clk);
    req_valid = 1'b0;
    chk({name, "_lat1_valid"}, 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk({name, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({name, "_data"}, rsp_data, 32'd7);
    chk({name, "_tag"}, 32'(rsp_tag), 32'd3);
    chk({name, "_err"}, 32'(rsp_err), 32'd0);
    chk({name, "_op_cnt"}, 32'(op_cnt), 32'(exp_op));
  endtask

  initial begin
    logic [2:0] legal[6];
    legal = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_tag", 32'(rsp_tag), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_op_cnt", 32'(op_cnt), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk_en = 1'b1;
    single_op("single", 16'd1);
    for (int i = 0; i < 6; i++) send(legal[i], 32'h9 + 32'(i), 32'h6, 4'(i));
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("b2b_op_cnt", 32'(op_cnt), 32'd7);
    send(3'd2, 32'h1234, 32'h1, 4'd8);
    send(3'd3, 32'h5678, 32'h2, 4'd9);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rsv_data", rsp_data, 32'd0);
    chk("rsv_err", 32'(rsp_err), 32'd1);
    repeat (3) @(negedge clk);
    chk("rsv_err_cnt", 32'(err_cnt), 32'd2);
    chk("rsv_op_cnt", 32'(op_cnt), 32'd7);
    rsp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      send(3'd1, 32'd100, 32'(i), 4'(i));
      if (req_ready) acc++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    chk("bp_accepts", 32'(acc), 32'd4);
    chk("bp_req_ready", 32'(req_ready), 32'd0);
    rsp_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("bp_recover_ready", 32'(req_ready), 32'd1);
    chk("bp_drained", 32'(rsp_valid), 32'd0);
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(3'd4, 32'hF0F0 + 32'(i), 32'hFF, 4'(i + 10));
    @(negedge clk);
    req_valid = 1'b0;
    chk("prerst_full", 32'(req_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(rsp_valid), 32'd0);
    chk("async_rst_op_cnt", 32'(op_cnt), 32'd0);
    chk("async_rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("async_rst_ready", 32'(req_ready), 32'd1);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    single_op("postrst", 16'd1);
    @(posedge clk);
    #2 force dut.op_cnt = 16'hFFFE;
    m_op = 16'hFFFE;
    #1 release dut.op_cnt;
    for (int i = 0; i < 3; i++) send(3'd5, 32'(i), 32'h10, 4'(i));
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("sat_op_cnt", 32'(op_cnt), 32'hFFFF);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      req_valid = ($urandom_range(0, 3) != 0);
      rsp_ready = ($urandom_range(0, 9) < 7);
      req_opcode = 3'($urandom_range(0, 7));
      req_in1 = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      req_in2 = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      req_tag = 4'($urandom);
    end
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (8) @(negedge clk);
    chk("final_empty", 32'(rsp_valid), 32'd0);
    chk("final_ready", 32'(req_ready), 32'd1);
    chk("final_op_sat", 32'(op_cnt), 32'hFFFF);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
